// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the SPI Gray-code receiver.
package spi_rx_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  // Widest frame the Gray decoder handles; narrower values are zero-extended.
  localparam int GRAY_MAX_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } rx_state_t;

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  // Zero-extended inputs decode correctly because the leading zeros contribute nothing.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = wptr - rptr;
  // Head entry is forced to zero while empty so the output has a defined reset value.
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer update; pointers are the only FIFO control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spi_gray_rx.sv
// SPI slave receiver: captures MSB-first frames on the shared clock, decodes
// Gray to binary, and buffers bytes on a valid/ready stream.
// Build option: define SPI_RX_GRAY_DECODE_EN to store decoded binary; when it
// is undefined the raw shift register is stored and the decoder is absent.
module spi_gray_rx
  import spi_rx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs,
  input  logic                          sclk,
  input  logic                          mosi,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int BW = $clog2(DATA_W + 2);
  localparam logic [BW-1:0] BIT_FULL = BW'(DATA_W);
  localparam logic [BW-1:0] BIT_SAT  = BW'(DATA_W + 1);

  // Saturating bit counter so excess clocks cannot wrap back to a good count.
  function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] c);
    return (c >= BIT_SAT) ? BIT_SAT : c + 1'b1;
  endfunction

  logic              cs_q;
  logic              sclk_q;
  logic              cs_fall;
  logic              cs_rise;
  logic              sclk_rise;
  rx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] push_data;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  // Input stage: one register per SPI line, same clock domain as the master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= 1'b1;
      sclk_q <= 1'b0;
    end else begin
      cs_q   <= cs;
      sclk_q <= sclk;
    end
  end

  assign cs_fall   = ~cs & cs_q;
  assign cs_rise   = cs & ~cs_q;
  assign sclk_rise = sclk & ~sclk_q & ~cs;

  // Frame FSM: shift while selected, accept only an exact DATA_W-bit frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state  <= SHIFT;
            shreg  <= '0;
            bitcnt <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if (bitcnt == BIT_FULL) begin
              state <= PUSH;
            end else begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            shreg  <= {shreg[DATA_W-2:0], mosi};
            bitcnt <= sat_inc(bitcnt);
          end
        end
        PUSH:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_RX_GRAY_DECODE_EN
  assign push_data = DATA_W'(gray2bin(GRAY_MAX_W'(shreg)));
`else
  assign push_data = shreg;
`endif

  assign fifo_push = (state == PUSH);
  assign fifo_pop  = rx_valid & rx_ready;
  assign rx_valid  = ~fifo_empty;

  // Overflow flags a completed frame lost to a full FIFO with no pop to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= fifo_push & fifo_full & ~fifo_pop;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_spi_gray_rx.sv
// Bench for spi_gray_rx: table-driven good frames through a scoreboard queue,
// plus hand-written sequences for framing errors, overflow and reset.
module tb_spi_gray_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int ovf_pulses = 0;
  int ferr_pulses = 0;
  int base_o;
  int base_f;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    logic [7:0] gray;
    logic [7:0] bin;
  } vec_t;
  vec_t vecs[6];

  spi_gray_rx #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .sclk       (sclk),
    .mosi       (mosi),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] expect_of(input logic [7:0] g, input logic [7:0] b);
`ifdef SPI_RX_GRAY_DECODE_EN
    return b;
`else
    return g;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] v, input int n);
    cs = 1'b0;
    tick();
    tick();
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      tick();
      sclk = 1'b1;
      tick();
      tick();
      sclk = 1'b0;
      tick();
    end
    mosi = 1'b0;
    cs   = 1'b1;
  endtask

  // Scoreboard: every accepted beat is compared against the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %02h, expected no data", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data: got %02h, expected %02h", rx_data, mon_exp);
        end
      end
    end
    if (overflow)  ovf_pulses++;
    if (frame_err) ferr_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{gray: 8'h00, bin: 8'h00};
    vecs[1] = '{gray: 8'h80, bin: 8'hFF};
    vecs[2] = '{gray: 8'hFF, bin: 8'hAA};
    vecs[3] = '{gray: 8'h01, bin: 8'h01};
    vecs[4] = '{gray: 8'hC0, bin: 8'h80};
    vecs[5] = '{gray: 8'h55, bin: 8'h66};

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Good frame with exact latency
    rx_ready = 1'b1;
    exp_q.push_back(expect_of(8'h3E, 8'h2B));
    send_frame(16'h003E, 8);
    @(negedge clk);
    @(negedge clk);
    chk("good_valid_e1", rx_valid, 0);
    @(negedge clk);
    chk("good_valid_e2", rx_valid, 1);
    chk("good_data", rx_data, expect_of(8'h3E, 8'h2B));
    @(negedge clk);
    chk("good_valid_e3", rx_valid, 0);
    chk("good_count", fifo_count, 0);
    tick();

    // Table of good frames
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(expect_of(vecs[i].gray, vecs[i].bin));
      send_frame({8'h00, vecs[i].gray}, 8);
      repeat (5) tick();
      chk($sformatf("vec%0d_count", i), fifo_count, 0);
    end
    chk("table_queue_drained", exp_q.size(), 0);
    chk("table_no_frame_err", ferr_pulses, 0);
    chk("table_no_overflow", ovf_pulses, 0);

    // Short frame
    base_f = ferr_pulses;
    send_frame(16'h0015, 5);
    @(negedge clk);
    @(negedge clk);
    chk("short_ferr_e1", frame_err, 1);
    @(negedge clk);
    chk("short_ferr_e2", frame_err, 0);
    tick();
    repeat (3) tick();
    chk("short_count", fifo_count, 0);
    chk("short_pulses", ferr_pulses - base_f, 1);

    // Long frame
    base_f = ferr_pulses;
    send_frame(16'h01AB, 9);
    repeat (5) tick();
    chk("long_count", fifo_count, 0);
    chk("long_valid", rx_valid, 0);
    chk("long_pulses", ferr_pulses - base_f, 1);

    // Zero-bit frame
    base_f = ferr_pulses;
    cs = 1'b0;
    tick();
    tick();
    cs = 1'b1;
    repeat (4) tick();
    chk("zero_pulses", ferr_pulses - base_f, 1);
    chk("zero_count", fifo_count, 0);

    // Overflow on fifth frame with consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(expect_of(8'h00, 8'h00));
    send_frame(16'h0000, 8); repeat (3) tick();
    exp_q.push_back(expect_of(8'h01, 8'h01));
    send_frame(16'h0001, 8); repeat (3) tick();
    exp_q.push_back(expect_of(8'h03, 8'h02));
    send_frame(16'h0003, 8); repeat (3) tick();
    exp_q.push_back(expect_of(8'h02, 8'h03));
    send_frame(16'h0002, 8); repeat (3) tick();
    chk("ovf_full_count", fifo_count, 4);
    base_o = ovf_pulses;
    send_frame(16'h0006, 8);
    @(negedge clk);
    @(negedge clk);
    chk("ovf_e1", overflow, 0);
    @(negedge clk);
    chk("ovf_e2", overflow, 1);
    @(negedge clk);
    chk("ovf_e3", overflow, 0);
    chk("ovf_count_kept", fifo_count, 4);
    tick();
    rx_ready = 1'b1;
    repeat (8) tick();
    rx_ready = 1'b0;
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_drain_count", fifo_count, 0);
    chk("ovf_pulses", ovf_pulses - base_o, 1);

    // Full FIFO with a pop in the push cycle
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(expect_of(vecs[i].gray, vecs[i].bin));
      send_frame({8'h00, vecs[i].gray}, 8);
      repeat (3) tick();
    end
    chk("fp_full_count", fifo_count, 4);
    base_o = ovf_pulses;
    exp_q.push_back(expect_of(vecs[4].gray, vecs[4].bin));
    send_frame({8'h00, vecs[4].gray}, 8);
    tick();
    rx_ready = 1'b1;
    @(negedge clk);
    tick();
    rx_ready = 1'b0;
    @(negedge clk);
    chk("fp_count_kept", fifo_count, 4);
    chk("fp_no_overflow", overflow, 0);
    tick();
    rx_ready = 1'b1;
    repeat (8) tick();
    rx_ready = 1'b0;
    chk("fp_drained", exp_q.size(), 0);
    chk("fp_drain_count", fifo_count, 0);
    chk("fp_ovf_pulses", ovf_pulses - base_o, 0);

    // Reset in the middle of a frame with data buffered
    exp_q.push_back(expect_of(vecs[5].gray, vecs[5].bin));
    send_frame({8'h00, vecs[5].gray}, 8);
    repeat (3) tick();
    chk("mr_pre_count", fifo_count, 1);
    exp_q.delete();
    cs = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      mosi = i[0];
      tick();
      sclk = 1'b1;
      tick();
      tick();
      sclk = 1'b0;
      tick();
    end
    base_o = ovf_pulses;
    base_f = ferr_pulses;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_rx_valid", rx_valid, 0);
    chk("mr_rx_data", rx_data, 0);
    chk("mr_fifo_count", fifo_count, 0);
    chk("mr_overflow", overflow, 0);
    chk("mr_frame_err", frame_err, 0);
    cs = 1'b1;
    mosi = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mr_no_ferr", ferr_pulses - base_f, 0);
    chk("mr_no_ovf", ovf_pulses - base_o, 0);
    chk("mr_idle_count", fifo_count, 0);

    rx_ready = 1'b1;
    exp_q.push_back(expect_of(8'h80, 8'hFF));
    send_frame(16'h0080, 8);
    repeat (5) tick();
    chk("mr_after_drained", exp_q.size(), 0);
    chk("mr_after_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
